// File: rtl/freq_gen_pkg.sv
// Shared definitions for the programmable square-wave generator.
package freq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned MIN_HALF = 1;

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one half-wave; reload sets the phase length, zero marks its last cycle.
module phase_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave source: burst or continuous output, load handshake,
// stop honoured only at a period boundary.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned BURST_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [CNT_W-1:0]   half_period,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               stop,
  output logic               ready,
  output logic               wave_out,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] pulse_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] pulse_q, pulse_d;
  logic               wave_q, wave_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               t_load;
  logic [CNT_W-1:0]   t_val;
  logic               t_zero;
  logic [CNT_W-1:0]   half_in;

  assign half_in = (half_period < CNT_W'(MIN_HALF)) ? CNT_W'(MIN_HALF) : half_period;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load_i  (t_load),
    .value_i (t_val),
    .zero_c  (t_zero)
  );

  // Next state; pulse_cnt doubles as the emitted-period count for burst termination.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    burst_d = burst_q;
    pulse_d = pulse_q;
    t_load  = 1'b0;
    t_val   = half_q - CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_HIGH;
          half_d  = half_in;
          burst_d = burst_len;
          pulse_d = BURST_W'(1);
          t_load  = 1'b1;
          t_val   = half_in - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (t_zero) begin
          state_d = ST_LOW;
          t_load  = 1'b1;
        end
      end
      ST_LOW: begin
        if (t_zero) begin
          if (stop) begin
            state_d = ST_DONE;
          end else if ((burst_q != '0) && (pulse_q == burst_q)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HIGH;
            t_load  = 1'b1;
            pulse_d = pulse_q + BURST_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    wave_d  = (state_d == ST_HIGH);
    busy_d  = (state_d == ST_HIGH) || (state_d == ST_LOW);
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      half_q  <= '0;
      burst_q <= '0;
      pulse_q <= '0;
      wave_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      burst_q <= burst_d;
      pulse_q <= pulse_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready     = ready_q;
  assign wave_out  = wave_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_cnt = pulse_q;

endmodule

// File: tb/tb_freq_gen.sv
// Bench for freq_gen: directed scenarios plus random traffic, checked every cycle against
// an arithmetic model of the waveform (cycle index since accept -> phase, period number).
module tb_freq_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld  [2];
  logic [31:0] hp  [2];
  logic [15:0] bl  [2];
  logic        stp [2];
  logic        rdy [2];
  logic        wav [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [15:0] pc0;
  logic [3:0]  pc1;

  always #5 clock = ~clock;

  freq_gen #(.CNT_W(32), .BURST_W(16)) dut (
    .clock(clock), .reset(reset), .load(ld[0]), .half_period(hp[0]),
    .burst_len(bl[0]), .stop(stp[0]), .ready(rdy[0]), .wave_out(wav[0]),
    .busy(bsy[0]), .done(dn[0]), .pulse_cnt(pc0)
  );

  freq_gen #(.CNT_W(32), .BURST_W(4)) dut4 (
    .clock(clock), .reset(reset), .load(ld[1]), .half_period(hp[1]),
    .burst_len(bl[1][3:0]), .stop(stp[1]), .ready(rdy[1]), .wave_out(wav[1]),
    .busy(bsy[1]), .done(dn[1]), .pulse_cnt(pc1)
  );

  // Model: while running, k counts cycles since the accept edge.
  int m_run [2];
  int m_dn  [2];
  int m_k   [2];
  int m_h   [2];
  int m_b   [2];
  int m_hold[2];
  int mask  [2];
  int cmp  = 0;
  int mism = 0;

  task automatic check(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      mism++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_run[i] = 0; m_dn[i] = 0; m_k[i] = 0; m_hold[i] = 0;
      end else if (m_dn[i] != 0) begin
        m_dn[i] = 0;
      end else if (m_run[i] != 0) begin
        if ((m_k[i] % (2 * m_h[i])) == (2 * m_h[i] - 1)) begin
          if (stp[i] || (m_b[i] != 0 && (m_k[i] / (2 * m_h[i]) + 1) == m_b[i])) begin
            m_run[i] = 0;
            m_dn[i]  = 1;
          end else begin
            m_k[i]++;
          end
        end else begin
          m_k[i]++;
        end
      end else if (ld[i]) begin
        m_run[i] = 1;
        m_k[i]   = 0;
        m_h[i]   = (hp[i] == 0) ? 1 : int'(hp[i]);
        m_b[i]   = int'(bl[i]) & mask[i];
      end
      if (m_run[i] != 0) m_hold[i] = (m_k[i] / (2 * m_h[i]) + 1) & mask[i];
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      int ew, eb, er, ed, act_pc;
      ew = 0; eb = 0; er = 0; ed = 0;
      if (m_run[i] != 0) begin
        ew = ((m_k[i] % (2 * m_h[i])) < m_h[i]) ? 1 : 0;
        eb = 1;
      end else if (m_dn[i] != 0) begin
        ed = 1;
      end else begin
        er = 1;
      end
      act_pc = (i == 0) ? int'(pc0) : int'(pc1);
      check($sformatf("wave_out[%0d]", i), int'(wav[i]), ew);
      check($sformatf("busy[%0d]", i), int'(bsy[i]), eb);
      check($sformatf("ready[%0d]", i), int'(rdy[i]), er);
      check($sformatf("done[%0d]", i), int'(dn[i]), ed);
      check($sformatf("pulse_cnt[%0d]", i), act_pc, m_hold[i]);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    model_step();
    compare_all();
  endtask

  // Advance until the instance reports done; n counts observed cycles since the accept.
  task automatic wait_done(input int i, input int budget, inout int n);
    while (!dn[i] && n < budget) begin
      cycle();
      n++;
    end
    if (!dn[i]) begin
      cmp++;
      mism++;
      $display("FAIL wait_done[%0d]: no done after %0d cycles, required done=1", i, n);
    end
  endtask

  task automatic start(input int i, input int h, input int b);
    ld[i] = 1'b1;
    hp[i] = 32'(h);
    bl[i] = 16'(b);
    cycle();
    ld[i] = 1'b0;
  endtask

  int n;

  initial begin
    mask[0] = 16'hFFFF;
    mask[1] = 4'hF;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld[i] = 1'b0; hp[i] = '0; bl[i] = '0; stp[i] = 1'b0;
      m_run[i] = 0; m_dn[i] = 0; m_k[i] = 0; m_h[i] = 1; m_b[i] = 0; m_hold[i] = 0;
    end
    cycle();
    cycle();
    reset = 1'b1;
    cycle();

    // Burst of 3 periods, half-period 5
    start(0, 5, 3);
    check("t1_first_wave", int'(wav[0]), 1);
    n = 1;
    wait_done(0, 200, n);
    check("t1_len", n, 31);
    check("t1_pulse", int'(pc0), 3);
    cycle();
    check("t1_ready", int'(rdy[0]), 1);

    // half_period 0 behaves as 1
    start(0, 0, 4);
    n = 1;
    wait_done(0, 200, n);
    check("t2_len", n, 9);
    check("t2_pulse", int'(pc0), 4);
    cycle();

    // Continuous; stop raised mid-HIGH of the 2nd period
    start(0, 10, 0);
    n = 1;
    repeat (24) begin cycle(); n++; end
    check("t3_mid_high", int'(wav[0]), 1);
    stp[0] = 1'b1;
    wait_done(0, 200, n);
    check("t3_len", n, 41);
    check("t3_pulse", int'(pc0), 2);
    stp[0] = 1'b0;
    cycle();

    // Load while busy is ignored
    start(0, 5, 2);
    n = 1;
    repeat (2) begin cycle(); n++; end
    ld[0] = 1'b1; hp[0] = 32'd2;
    cycle(); n++;
    ld[0] = 1'b0;
    check("t4_ready_busy", int'(rdy[0]), 0);
    wait_done(0, 200, n);
    check("t4_len", n, 21);
    check("t4_pulse", int'(pc0), 2);
    cycle();

    // Asynchronous reset mid-HIGH
    start(0, 5, 0);
    repeat (2) cycle();
    #2 reset = 1'b0;
    #1;
    check("t5_wave_async", int'(wav[0]), 0);
    check("t5_busy_async", int'(bsy[0]), 0);
    check("t5_ready_async", int'(rdy[0]), 1);
    check("t5_pulse_async", int'(pc0), 0);
    cycle();
    reset = 1'b1;
    start(0, 3, 1);
    check("t5_pulse_restart", int'(pc0), 1);
    check("t5_wave_restart", int'(wav[0]), 1);
    n = 1;
    wait_done(0, 200, n);
    check("t5_len", n, 7);
    cycle();

    // 4-bit pulse counter wraps: 20 rises read back as 4
    start(1, 1, 0);
    n = 1;
    repeat (39) begin cycle(); n++; end
    check("t6_wrap", int'(pc1), 4);
    stp[1] = 1'b1;
    wait_done(1, 200, n);
    stp[1] = 1'b0;
    cycle();

    // Random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        ld[i]  = ($urandom_range(0, 7) == 0);
        hp[i]  = 32'($urandom_range(0, 6));
        bl[i]  = 16'($urandom_range(0, 3));
        stp[i] = ($urandom_range(0, 15) == 0);
      end
      cycle();
    end

    for (int i = 0; i < 2; i++) begin
      ld[i] = 1'b0;
      stp[i] = 1'b1;
    end
    repeat (40) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
